// File: rtl/huedeon_pixel_writer.sv
// Pixel write buffer: packs RGB888 pixels into RGB565 and queues them,
// then issues one framebuffer write request at a time on a req/ack handshake.
module huedeon_pixel_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wr_enable,
  input  logic [ADDR_WIDTH-1:0] i_wr_address,
  input  logic [7:0]            i_r,
  input  logic [7:0]            i_g,
  input  logic [7:0]            i_b,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_data,
  input  logic                  i_mem_ack,
  output logic                  o_full,
  output logic                  o_idle,
  output logic                  o_overflow,
  output logic [15:0]           o_drop_count,
  input  logic                  i_clear_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + 16;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]           mem_data_q, mem_data_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_count_q, drop_count_d;
  logic                  full_q, full_d;
  logic                  idle_q, idle_d;

  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic [EW-1:0]         head_s;
  logic [EW-1:0]         next_s;

  // Handshake qualifiers; a same-edge pop frees a slot for the incoming pixel.
  always_comb begin
    full_s = (count_q == DEPTH_C);
    pop_s  = (state_q == REQ) && i_mem_ack;
    push_s = i_wr_enable && (!full_s || pop_s);
    drop_s = i_wr_enable && full_s && !pop_s;
    head_s = fifo_mem[rd_ptr_q];
    next_s = fifo_mem[rd_ptr_q + PW'(1)];
  end

  // Request FSM: the head stays counted until acked, so "another entry" means count > 1.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          mem_addr_d = head_s[EW-1:16];
          mem_data_d = head_s[15:0];
          mem_req_d  = 1'b1;
          state_d    = REQ;
        end else begin
          mem_req_d  = 1'b0;
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (count_q > CW'(1)) begin
            mem_addr_d = next_s[EW-1:16];
            mem_data_d = next_s[15:0];
            mem_req_d  = 1'b1;
          end else begin
            mem_req_d  = 1'b0;
            state_d    = IDLE;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Occupancy, write pointer, drop bookkeeping and registered status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Clear acts first so a coincident drop is counted afresh.
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (i_clear_overflow) begin
      overflow_d   = drop_s;
      drop_count_d = drop_s ? 16'd1 : 16'd0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end

    full_d = (count_d == DEPTH_C);
    idle_d = (count_d == {CW{1'b0}}) && (state_d == IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_data_q   <= 16'd0;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'd0;
      full_q       <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      full_q       <= full_d;
      idle_q       <= idle_d;
    end
  end

  // Pixel storage, packed at push time; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && push_s) begin
      fifo_mem[wr_ptr_q] <= {i_wr_address, pack_rgb565(i_r, i_g, i_b)};
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_full       = full_q;
  assign o_idle       = idle_q;
  assign o_overflow   = overflow_q;
  assign o_drop_count = drop_count_q;

endmodule

// File: tb/tb_huedeon_pixel_writer.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_huedeon_pixel_writer;

  localparam int DEPTH = 8;
  localparam int AW    = 18;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_wr_enable;
  logic [AW-1:0] i_wr_address;
  logic [7:0]    i_r, i_g, i_b;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic [15:0]   o_mem_data;
  logic          i_mem_ack;
  logic          o_full, o_idle, o_overflow;
  logic [15:0]   o_drop_count;
  logic          i_clear_overflow;

  int checks = 0;
  int errors = 0;

  huedeon_pixel_writer #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr_enable(i_wr_enable),
    .i_wr_address(i_wr_address), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_ack(i_mem_ack), .o_full(o_full), .o_idle(o_idle),
    .o_overflow(o_overflow), .o_drop_count(o_drop_count),
    .i_clear_overflow(i_clear_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: queue of accepted pixels (head included until acked).
  logic [AW+15:0] mq[$];
  bit             m_req;
  logic [AW+15:0] m_cur;
  bit             m_ovf;
  int             m_drops;
  int             delivered;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int n;
    bit pop, push, drop;
    logic [15:0] pix;
    if (!i_reset_n) begin
      mq.delete();
      m_req = 0; m_cur = '0; m_ovf = 0; m_drops = 0;
    end else begin
      n    = mq.size();
      pop  = m_req && i_mem_ack;
      push = i_wr_enable && ((n < DEPTH) || pop);
      drop = i_wr_enable && (n == DEPTH) && !pop;
      if (pop) begin
        delivered++;
        mq.delete(0);
        if (n > 1) m_cur = mq[0];
        else m_req = 0;
      end else if (!m_req && n > 0) begin
        m_req = 1;
        m_cur = mq[0];
      end
      pix = {i_r[7:3], i_g[7:2], i_b[7:3]};
      if (push) mq.push_back({i_wr_address, pix});
      if (i_clear_overflow) begin
        m_ovf = 0; m_drops = 0;
      end
      if (drop) begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic compare();
    chk("req", {31'd0, o_mem_req}, {31'd0, m_req});
    if (m_req) begin
      chk("addr", {14'd0, o_mem_addr}, {14'd0, m_cur[AW+15:16]});
      chk("data", {16'd0, o_mem_data}, {16'd0, m_cur[15:0]});
    end
    chk("full", {31'd0, o_full}, {31'd0, (mq.size() == DEPTH)});
    chk("idle", {31'd0, o_idle}, {31'd0, (mq.size() == 0 && !m_req)});
    chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    chk("drop_count", {16'd0, o_drop_count}, m_drops);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic rand_pixel();
    i_wr_address = AW'($urandom);
    i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
  endtask

  int first_hi, last_hi, n_hi, d0;

  initial begin
    i_reset_n = 1'b0; i_wr_enable = 1'b0; i_wr_address = '0;
    i_r = 8'd0; i_g = 8'd0; i_b = 8'd0; i_mem_ack = 1'b0; i_clear_overflow = 1'b0;
    delivered = 0; m_req = 0; m_cur = '0; m_ovf = 0; m_drops = 0;
    #1;
    tick(); tick();
    chk("rst_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_full", {31'd0, o_full}, 32'd0);
    chk("rst_idle", {31'd0, o_idle}, 32'd1);
    chk("rst_drops", {16'd0, o_drop_count}, 32'd0);
    i_reset_n = 1'b1;
    tick();

    // Single pixel
    i_wr_enable = 1'b1; i_wr_address = 18'h00140; i_r = 8'hFF; i_g = 8'h80; i_b = 8'h08;
    tick();                               // edge 0
    i_wr_enable = 1'b0;
    tick();                               // edge 1
    chk("single_req", {31'd0, o_mem_req}, 32'd1);
    chk("single_data", {16'd0, o_mem_data}, 32'h0000FC01);
    chk("single_addr", {14'd0, o_mem_addr}, 32'h00000140);
    tick();                               // edge 2
    chk("single_hold", {16'd0, o_mem_data}, 32'h0000FC01);
    i_mem_ack = 1'b1;
    tick();                               // edge 3
    i_mem_ack = 1'b0;
    chk("single_done_req", {31'd0, o_mem_req}, 32'd0);
    chk("single_done_idle", {31'd0, o_idle}, 32'd1);

    // Stream of 20 with ack held high
    i_mem_ack = 1'b1; first_hi = -1; last_hi = -1; n_hi = 0; d0 = delivered;
    for (int e = 0; e < 24; e++) begin
      i_wr_enable = (e < 20);
      rand_pixel();
      tick();
      if (o_mem_req) begin
        if (first_hi < 0) first_hi = e;
        last_hi = e;
        n_hi++;
      end
    end
    i_wr_enable = 1'b0; i_mem_ack = 1'b0;
    chk("stream_first", first_hi, 32'd1);
    chk("stream_last", last_hi, 32'd20);
    chk("stream_cycles", n_hi, 32'd20);
    chk("stream_delivered", delivered - d0, 32'd20);
    chk("stream_drops", {16'd0, o_drop_count}, 32'd0);

    // Overflow: 10 pushes with ack low
    for (int i = 0; i < 10; i++) begin
      i_wr_enable = 1'b1; rand_pixel(); tick();
    end
    chk("ovf_full", {31'd0, o_full}, 32'd1);
    chk("ovf_drops", {16'd0, o_drop_count}, 32'd2);
    chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
    // Full with push and ack on the same edge
    i_mem_ack = 1'b1; rand_pixel(); tick();
    chk("fullpa_full", {31'd0, o_full}, 32'd1);
    chk("fullpa_drops", {16'd0, o_drop_count}, 32'd2);
    i_wr_enable = 1'b0; d0 = delivered;
    for (int i = 0; i < 8; i++) tick();
    i_mem_ack = 1'b0;
    chk("drain_delivered", delivered - d0, 32'd8);
    chk("drain_idle", {31'd0, o_idle}, 32'd1);
    i_clear_overflow = 1'b1; tick(); i_clear_overflow = 1'b0;
    chk("clear_drops", {16'd0, o_drop_count}, 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      i_wr_enable = 1'b1; rand_pixel(); tick();
    end
    i_wr_enable = 1'b0; tick();
    chk("pre_rst_req", {31'd0, o_mem_req}, 32'd1);
    i_reset_n = 1'b0; i_wr_enable = 1'b1; tick();
    i_reset_n = 1'b1; i_wr_enable = 1'b0;
    chk("midrst_req", {31'd0, o_mem_req}, 32'd0);
    chk("midrst_idle", {31'd0, o_idle}, 32'd1);
    i_mem_ack = 1'b1; tick(); tick(); i_mem_ack = 1'b0;
    chk("late_ack_req", {31'd0, o_mem_req}, 32'd0);
    chk("late_ack_idle", {31'd0, o_idle}, 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      i_wr_enable      = ($urandom_range(0, 99) < 60);
      i_mem_ack        = ($urandom_range(0, 99) < 45);
      i_clear_overflow = ($urandom_range(0, 99) < 2);
      i_reset_n        = ($urandom_range(0, 499) != 0);
      rand_pixel();
      tick();
    end
    i_wr_enable = 1'b0; i_mem_ack = 1'b0; i_reset_n = 1'b1;
    i_clear_overflow = 1'b1; tick(); i_clear_overflow = 1'b0;

    // Saturating drop counter
    i_wr_enable = 1'b1;
    for (int i = 0; i < 70008; i++) begin
      rand_pixel(); tick();
    end
    chk("sat_drops", {16'd0, o_drop_count}, 32'h0000FFFF);
    i_clear_overflow = 1'b1; tick();
    i_clear_overflow = 1'b0; i_wr_enable = 1'b0;
    chk("clr_drop_count", {16'd0, o_drop_count}, 32'd1);
    chk("clr_drop_flag", {31'd0, o_overflow}, 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huedeon_pixel_writer.md
HUEDEON_PIXEL_WRITER -- requirements
Module: huedeon_pixel_writer

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-low.
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the number of pixel entries; it SHALL be a power of two, 2..64.
REQ-003 Parameter ADDR_WIDTH, default 18, SHALL set the framebuffer word-address width.
REQ-004 i_clk  in  1  SHALL be the clock; every register updates on its rising edge.
REQ-005 i_reset_n  in  1  SHALL be the synchronous active-low reset.
REQ-006 i_wr_enable  in  1  SHALL be the pixel-write strobe from the raster engine; one pixel per cycle in which it is high.
REQ-007 i_wr_address  in  ADDR_WIDTH  SHALL be the framebuffer word address of the pixel.
REQ-008 i_r, i_g, i_b  in  8 each  SHALL be the pixel colour, RGB888.
REQ-009 o_mem_req  out  1  SHALL be the memory write request.
REQ-010 o_mem_addr  out  ADDR_WIDTH  SHALL be the write address.
REQ-011 o_mem_data  out  16  SHALL be the RGB565 write data.
REQ-012 i_mem_ack  in  1  SHALL be the memory acknowledge; it completes the current request.
REQ-013 o_full  out  1  SHALL be the FIFO-full flag.
REQ-014 o_idle  out  1  SHALL be high when the FIFO is empty and no request is outstanding.
REQ-015 o_overflow  out  1  SHALL be a sticky flag set when a pixel is dropped.
REQ-016 o_drop_count  out  16  SHALL be a saturating count of dropped pixels.
REQ-017 i_clear_overflow  in  1  SHALL clear o_overflow and o_drop_count.

Function
REQ-018 Packing SHALL take place at push: data = {r[7:3], g[7:2], b[7:3]}.
REQ-019 A push SHALL occur on an edge where i_wr_enable=1 and the FIFO is not full; the FIFO SHALL be checked for fullness after any pop on that same edge.
REQ-020 When i_wr_enable=1 and the FIFO is full with no pop on the same edge, the pixel SHALL be dropped, o_overflow SHALL be set, and o_drop_count SHALL increment, saturating at 0xFFFF.
REQ-021 When i_clear_overflow and a drop coincide, the clear SHALL take effect first and then the drop SHALL be counted: o_overflow=1, count=1.
REQ-022 The FSM SHALL have two states, IDLE and REQ.
REQ-023 In IDLE with the FIFO non-empty, on the next edge the FSM SHALL load the head entry into o_mem_addr/o_mem_data, set o_mem_req=1, and enter REQ.
REQ-024 In REQ, o_mem_req, o_mem_addr and o_mem_data SHALL hold stable until an edge with i_mem_ack=1.
REQ-025 On ack the head entry SHALL be popped.
REQ-026 On ack, if another entry exists, excluding any entry pushed on that same edge, it SHALL be loaded and o_mem_req SHALL stay 1; otherwise the FSM SHALL go to IDLE with o_mem_req=0.
REQ-027 i_mem_ack SHALL be ignored in IDLE.
REQ-028 Latency: a pixel pushed into an empty FIFO on edge k SHALL present o_mem_req=1 after edge k+1.
REQ-029 Sustained throughput SHALL be one pixel per cycle when i_mem_ack is held high.
REQ-030 Pixel order SHALL be preserved: strict FIFO, no coalescing of writes to the same address.
REQ-031 The read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 Occupancy SHALL be tracked by a count of width log2(FIFO_DEPTH)+1.
REQ-033 o_full SHALL equal (count == FIFO_DEPTH).
REQ-034 o_idle SHALL equal (count == 0 and state == IDLE).
REQ-035 The head entry SHALL remain counted in the FIFO until its ack.

Reset
REQ-036 While i_reset_n=0 at an edge, the block SHALL set: state IDLE, pointers 0, count 0, o_mem_req=0, o_mem_addr=0, o_mem_data=0, o_overflow=0, o_drop_count=0.
REQ-037 During reset, o_full=0 and o_idle=1 SHALL follow from the reset state.
REQ-038 A reset mid-request SHALL discard the outstanding request and all queued pixels; o_mem_req SHALL be 0 after that edge.
REQ-039 A late i_mem_ack after reset SHALL be ignored.
REQ-040 Pushes SHALL be ignored on a reset edge.
REQ-041 FIFO storage contents SHALL need no reset.

Verification
REQ-042 Single pixel: addr 0x00140, RGB FF/80/08, push at edge 0, ack at edge 3 -> o_mem_req high cycles 1-3, o_mem_data=0xFC01, o_mem_addr=0x00140, o_idle=1 after edge 3.
REQ-043 Stream: 20 consecutive pushes with i_mem_ack tied high -> 20 requests in order, no drops, o_mem_req high continuously from cycle 1 to cycle 20.
REQ-044 Overflow: ack low, 10 pushes with depth 8 -> o_full=1 after 8 pushes, o_drop_count=2, o_overflow=1; then 8 acks -> 8 pixels delivered, the first 8 in order.
REQ-045 Full plus simultaneous push and ack: FIFO full, push and ack on the same edge -> push accepted, count stays 8, no drop.
REQ-046 Reset mid-operation: 5 queued, request outstanding, i_reset_n=0 for one edge -> o_mem_req=0 and o_idle=1; a later ack produces no request.
REQ-047 Drop counter: 70000 drops -> o_drop_count=0xFFFF; then i_clear_overflow plus one drop on the same edge -> count=1, o_overflow=1.
